// File: rtl/max_serial.sv
// Serial max reducer: finds the largest of N_CH consecutive accepted
// samples and reports its value and channel index.
module max_serial #(
    parameter int WIDTH  = 8,
    parameter int N_CH   = 10,
    parameter bit SIGNED = 1'b0,
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] data_out,
    output logic [IDX_W-1:0] idx_out,
    output logic             valid_out,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CH - 1);

    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] cnt_eff;
    logic [IDX_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] acc_max;
    logic [IDX_W-1:0] acc_idx;
    logic             first;
    logic             last;
    logic             take;

    function automatic logic gt(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        if (SIGNED)
            return $signed(a) > $signed(b);
        return a > b;
    endfunction

    // clr folds into the slot position so a sample arriving with clr
    // becomes sample 0 of a fresh frame.
    always_comb begin
        cnt_eff = clr ? '0 : cnt;
        first   = (cnt_eff == '0);
        last    = (cnt_eff == LAST);
        take    = first || gt(data_in, acc_max);
        cnt_nxt = cnt;
        if (valid_in)
            cnt_nxt = last ? '0 : cnt_eff + IDX_W'(1);
        else if (clr)
            cnt_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            acc_max   <= '0;
            acc_idx   <= '0;
            data_out  <= '0;
            idx_out   <= '0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            busy      <= (cnt_nxt != '0);
            valid_out <= valid_in && last;
            if (valid_in) begin
                if (last) begin
                    data_out <= take ? data_in : acc_max;
                    idx_out  <= take ? cnt_eff : acc_idx;
                end else if (take) begin
                    acc_max <= data_in;
                    acc_idx <= cnt_eff;
                end
            end
        end
    end

endmodule

// File: tb/tb_max_serial.sv
// Directed bench for max_serial: unsigned, signed and single-channel
// instances share one stimulus stream.
module tb_max_serial;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] data_in = '0;
    logic       valid_in = 1'b0;

    logic [7:0] u_data;
    logic [3:0] u_idx;
    logic       u_valid;
    logic       u_busy;
    logic [7:0] s_data;
    logic [3:0] s_idx;
    logic       s_valid;
    logic       s_busy;
    logic [7:0] o_data;
    logic [0:0] o_idx;
    logic       o_valid;
    logic       o_busy;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse = 0;
    int gap = 0;

    always #5 clk = ~clk;

    max_serial #(.WIDTH(8), .N_CH(10), .SIGNED(1'b0)) u_dut (
        .clk(clk), .reset(reset), .clr(clr),
        .data_in(data_in), .valid_in(valid_in),
        .data_out(u_data), .idx_out(u_idx),
        .valid_out(u_valid), .busy(u_busy)
    );

    max_serial #(.WIDTH(8), .N_CH(10), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .reset(reset), .clr(clr),
        .data_in(data_in), .valid_in(valid_in),
        .data_out(s_data), .idx_out(s_idx),
        .valid_out(s_valid), .busy(s_busy)
    );

    max_serial #(.WIDTH(8), .N_CH(1), .SIGNED(1'b0)) u_dut_one (
        .clk(clk), .reset(reset), .clr(clr),
        .data_in(data_in), .valid_in(valid_in),
        .data_out(o_data), .idx_out(o_idx),
        .valid_out(o_valid), .busy(o_busy)
    );

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    // One clock with the given inputs; outputs are observed on the
    // following falling edge.
    task automatic step(
        input logic [7:0] d,
        input logic       v,
        input logic       c,
        input logic       r
    );
        data_in  = d;
        valid_in = v;
        clr      = c;
        reset    = r;
        @(negedge clk);
        cyc++;
        if (u_valid) begin
            pulses++;
            gap = cyc - last_pulse;
            last_pulse = cyc;
        end
    endtask

    task automatic idle();
        step(8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [7:0] fa[10];
    logic [7:0] sv[10];
    int p0;

    initial begin
        fa = '{8'd3, 8'd7, 8'd2, 8'd9, 8'd1, 8'd9, 8'd0, 8'd5, 8'd4, 8'd8};
        sv = '{8'h80, 8'hFF, 8'h05, 8'h7F, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        @(negedge clk);
        step(8'd0, 1'b0, 1'b0, 1'b1);
        step(8'd0, 1'b0, 1'b0, 1'b1);
        check("rst_data", u_data, 0);
        check("rst_idx", u_idx, 0);
        check("rst_valid", u_valid, 0);
        check("rst_busy", u_busy, 0);
        idle();

        // Frame A then frame B with no gap
        for (int i = 0; i < 10; i++) begin
            step(fa[i], 1'b1, 1'b0, 1'b0);
            check($sformatf("a_valid%0d", i), u_valid, (i == 9));
        end
        check("a_data", u_data, 9);
        check("a_idx", u_idx, 3);
        for (int i = 0; i < 10; i++) begin
            step(8'(10 * (i + 1)), 1'b1, 1'b0, 1'b0);
            check($sformatf("b_valid%0d", i), u_valid, (i == 9));
        end
        check("b_gap", gap, 10);
        check("b_data", u_data, 100);
        check("b_idx", u_idx, 9);
        idle();
        check("b_pulse_end", u_valid, 0);
        check("b_hold", u_data, 100);

        // Gapped frame A
        for (int i = 0; i < 10; i++) begin
            step(fa[i], 1'b1, 1'b0, 1'b0);
            if (i == 0)
                check("g_busy_first", u_busy, 1);
            if (i == 1 || i == 5) begin
                idle();
                idle();
                check($sformatf("g_busy_gap%0d", i), u_busy, 1);
                check($sformatf("g_novalid%0d", i), u_valid, 0);
            end
        end
        check("g_valid", u_valid, 1);
        check("g_busy_end", u_busy, 0);
        check("g_data", u_data, 9);
        check("g_idx", u_idx, 3);
        idle();

        // Signed vs unsigned compare
        for (int i = 0; i < 10; i++)
            step(sv[i], 1'b1, 1'b0, 1'b0);
        check("s_valid", s_valid, 1);
        check("s_data", s_data, 8'h7F);
        check("s_idx", s_idx, 3);
        check("us_data", u_data, 8'hFF);
        check("us_idx", u_idx, 1);
        idle();

        // clr without valid, then a clean frame of fives
        step(8'd200, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(8'd1, 1'b1, 1'b0, 1'b0);
        check("c_busy_pre", u_busy, 1);
        p0 = pulses;
        step(8'd0, 1'b0, 1'b1, 1'b0);
        check("c_busy_clr", u_busy, 0);
        check("c_valid_clr", u_valid, 0);
        check("c_data_hold", u_data, 8'hFF);
        for (int i = 0; i < 10; i++)
            step(8'd5, 1'b1, 1'b0, 1'b0);
        check("c_pulses", pulses - p0, 1);
        check("c_valid", u_valid, 1);
        check("c_data", u_data, 5);
        check("c_idx", u_idx, 0);

        // clr together with a valid sample
        step(8'd200, 1'b1, 1'b0, 1'b0);
        step(8'd200, 1'b1, 1'b0, 1'b0);
        p0 = pulses;
        step(8'd6, 1'b1, 1'b1, 1'b0);
        check("cv_busy", u_busy, 1);
        for (int i = 0; i < 9; i++)
            step(8'd5, 1'b1, 1'b0, 1'b0);
        check("cv_pulses", pulses - p0, 1);
        check("cv_valid", u_valid, 1);
        check("cv_data", u_data, 6);
        check("cv_idx", u_idx, 0);
        idle();

        // Reset mid-frame
        for (int i = 0; i < 3; i++)
            step(8'd50, 1'b1, 1'b0, 1'b0);
        step(8'd0, 1'b0, 1'b0, 1'b1);
        check("rm_data", u_data, 0);
        check("rm_idx", u_idx, 0);
        check("rm_busy", u_busy, 0);
        check("rm_valid", u_valid, 0);

        // Reset on the valid_out cycle
        for (int i = 0; i < 10; i++)
            step(8'd77, 1'b1, 1'b0, 1'b0);
        check("rv_pre", u_valid, 1);
        step(8'd0, 1'b1, 1'b0, 1'b1);
        check("rv_valid", u_valid, 0);
        check("rv_data", u_data, 0);
        check("rv_busy", u_busy, 0);
        for (int i = 0; i < 10; i++)
            step(8'(i + 1), 1'b1, 1'b0, 1'b0);
        check("rf_valid", u_valid, 1);
        check("rf_data", u_data, 10);
        check("rf_idx", u_idx, 9);
        idle();

        // Single-channel frames
        step(8'd42, 1'b1, 1'b0, 1'b0);
        check("one_valid", o_valid, 1);
        check("one_data", o_data, 42);
        check("one_idx", o_idx, 0);
        check("one_busy", o_busy, 0);
        idle();
        check("one_idle", o_valid, 0);
        check("one_hold", o_data, 42);
        step(8'd13, 1'b1, 1'b1, 1'b0);
        check("one_clr_valid", o_valid, 1);
        check("one_clr_data", o_data, 13);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/max_serial.md
Name: max_serial

Overview:
- Sequential counterpart of the parallel max reducer: accepts one channel sample per clock on a valid-qualified stream.
- Finds the maximum over a frame of N_CH consecutive accepted samples and reports the maximum value and its channel index.
- Used where channel data is time-multiplexed on a single bus rather than presented as a flat N_CH-wide vector.

Parameters:
- WIDTH, 8, sample width in bits.
- N_CH, 10, samples per frame (>=1).
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.
- IDX_W, $clog2(N_CH) (minimum 1), width of index output; derived, not overridden.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- clr  in  1  synchronous frame abort; restarts frame counting.
- data_in  in  WIDTH  channel sample.
- valid_in  in  1  data_in is valid this cycle; sample accepted when high.
- data_out  out  WIDTH  maximum value of last completed frame.
- idx_out  out  IDX_W  channel index (0..N_CH-1) of that maximum.
- valid_out  out  1  one-cycle pulse when data_out/idx_out update.
- busy  out  1  high while a frame is partially accumulated (cnt != 0).

Behaviour:
- Reset: cnt=0, acc_max=0, acc_idx=0, data_out=0, idx_out=0, valid_out=0, busy=0. Reset dominates clr and valid_in.
- Always ready; no backpressure. Gaps in valid_in are allowed: cnt and the accumulators hold while valid_in=0.
- cnt counts accepted samples, 0..N_CH-1. It wraps to 0 after the sample accepted at cnt=N_CH-1.
- Sample at cnt=0 loads acc_max=data_in and acc_idx=0 unconditionally.
- Sample at cnt=k>0: if data_in > acc_max (strict, per SIGNED), load acc_max=data_in and acc_idx=k. Otherwise hold.
- Ties keep the earliest index.
- Final sample (cnt=N_CH-1): the winner of acc vs data_in (same strict rule) is registered into data_out/idx_out, and valid_out=1 on the next cycle.
  - Latency: 1 clock from the last accepted sample to valid_out.
  - The final sample does not need to be written to acc.
- data_out/idx_out hold their value until the next frame completes. valid_out is high for exactly one cycle per completed frame.
- Back-to-back frames with continuous valid_in are supported. Throughput is one frame per N_CH cycles, with no bubble.
- N_CH=1: every accepted sample produces valid_out next cycle with idx_out=0.
- clr=1 without valid_in: cnt->0, partial frame discarded, no valid_out, busy->0. data_out/idx_out are unchanged.
- clr=1 with valid_in=1 in the same cycle: the partial frame is discarded and data_in is taken as sample 0 of a new frame (cnt->1; or, if N_CH=1, a result is produced).
- clr on the cycle valid_out is high: the pulse is not suppressed, since that result is already registered.
- busy = (cnt != 0), registered.
- SIGNED=1: compare data_in and acc_max as signed WIDTH-bit values. Output values are raw, not sign-extended.

Test Plan:
- Unsigned, N_CH=10, continuous valid, samples 3,7,2,9,1,9,0,5,4,8 -> valid_out 1 cycle after 10th sample, data_out=9, idx_out=3 (tie at 5 ignored); valid_out exactly one cycle wide.
- Back-to-back frames: frame A as above, then frame B of 10,20,..,100 with no gap -> two pulses exactly 10 cycles apart; second gives data_out=100, idx_out=9.
- Gapped valid: same frame A, valid_in low 2 cycles after samples 2 and 6 -> same result (9,3); busy high from after sample 1 until after sample 10.
- SIGNED=1, WIDTH=8: samples 0x80,0xFF,0x05,0x7F,... (rest 0x00) -> data_out=0x7F, idx_out=3; with SIGNED=0 the same stimulus gives data_out=0xFF, idx_out=1.
- clr after 4 samples (values 200,1,1,1), then 10 samples all 5 -> single valid_out, data_out=5, idx_out=0. Repeat with clr asserted together with valid_in carrying 6, then 9 more samples of 5 -> data_out=6, idx_out=0.
- reset asserted mid-frame and on a valid_out cycle -> next cycle all outputs 0, busy=0. A following full frame 1..10 yields data_out=10, idx_out=9.
